// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_target
// Description : Mode-0 SPI target, MSB first, full duplex. SCLK, SS_N and
//               MOSI are oversampled in the system clock domain. A TX
//               holding register feeds the MISO shifter; received words
//               are presented with a single-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  ss_ni,
    input  logic                  sd_i,
    output logic                  sd_o,
    output logic                  sd_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Synchronizer chains plus a third stage for edge detection
    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic r_ss_meta, r_ss_sync, r_ss_d;
    logic r_sd_meta, r_sd_sync;
    // Registered single-cycle edge strobes
    logic r_sclk_rise, r_sclk_fall, r_ss_rise, r_ss_fall;
    // r_live[1] marks that the ss sync stage holds a genuine sample;
    // r_armed is set once ss_n has really been seen high since reset.
    logic [1:0] r_live;
    logic       r_armed;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic                    r_first;
    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_shift;
    logic                    r_hold_full;
    logic [DATA_WIDTH-1:0]   r_hold_data;

    logic w_start;
    logic w_reload;
    logic w_load;

    // Frame start, and word-boundary reload on SCLK fall (ss_n rise and
    // sclk rise take precedence over a fall in the same cycle).
    assign w_start  = (r_state == S_IDLE) && r_ss_fall && r_armed;
    assign w_reload = (r_state == S_ACTIVE) && !r_ss_rise && !r_sclk_rise &&
                      r_sclk_fall && (r_bit_cnt == '0) && !r_first;
    assign w_load   = w_start || w_reload;

    assign tx_ready_o = ~r_hold_full;

    // Oversample the SPI pins and derive registered edge strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_d      <= 1'b1;
            r_sd_meta   <= 1'b0;
            r_sd_sync   <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_live      <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_meta <= sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_ss_meta   <= ss_ni;
            r_ss_sync   <= r_ss_meta;
            r_ss_d      <= r_ss_sync;
            r_sd_meta   <= sd_i;
            r_sd_sync   <= r_sd_meta;
            r_sclk_rise <= r_sclk_sync & ~r_sclk_d;
            r_sclk_fall <= ~r_sclk_sync & r_sclk_d;
            r_ss_rise   <= r_ss_sync & ~r_ss_d;
            r_ss_fall   <= ~r_ss_sync & r_ss_d;
            r_live      <= {r_live[0], 1'b1};
            if (r_live[1] && r_ss_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // TX holding register: accept when empty, empty when loaded to shifter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (tx_valid_i && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold_data <= tx_data_i;
        end
    end

    // Frame state machine with shifters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_first       <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            sd_o          <= 1'b0;
            sd_oe_o       <= 1'b0;
            busy_o        <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;

            if (w_load) begin
                if (r_hold_full) begin
                    r_tx_shift <= r_hold_data;
                end else begin
                    r_tx_shift    <= IDLE_WORD;
                    tx_underrun_o <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_ACTIVE;
                        r_bit_cnt <= '0;
                        r_first   <= 1'b1;
                        sd_oe_o   <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    sd_o <= r_tx_shift[DATA_WIDTH-1];
                    if (r_ss_rise) begin
                        // Partial RX bits are simply dropped
                        r_state   <= S_IDLE;
                        r_bit_cnt <= '0;
                        sd_oe_o   <= 1'b0;
                        busy_o    <= 1'b0;
                    end else if (r_sclk_rise) begin
                        r_first    <= 1'b0;
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], r_sd_sync};
                        if (r_bit_cnt == c_LAST_BIT) begin
                            rx_data_o  <= {r_rx_shift[DATA_WIDTH-2:0], r_sd_sync};
                            rx_valid_o <= 1'b1;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (r_sclk_fall && !w_reload) begin
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_target
// Description : Directed self-checking bench for spi_target. A scoreboard
//               queue holds the words the host sends; a monitor pops and
//               compares them on each rx_valid_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    logic       clk_i      = 1'b0;
    logic       rst_ni     = 1'b0;
    logic       sclk_i     = 1'b0;
    logic       ss_ni      = 1'b1;
    logic       sd_i       = 1'b0;
    logic [7:0] tx_data_i  = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       sd_o;
    logic       sd_oe_o;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       tx_underrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    logic [7:0] exp_rx_q[$];

    spi_target #(
        .DATA_WIDTH (8),
        .IDLE_WORD  (8'hFF)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sclk_i        (sclk_i),
        .ss_ni         (ss_ni),
        .sd_i          (sd_i),
        .sd_o          (sd_o),
        .sd_oe_o       (sd_oe_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every rx pulse must match the oldest queued word
    always @(negedge clk_i) begin
        if (tx_underrun_o) ur_cnt++;
        if (rx_valid_o) begin
            rx_cnt++;
            checks++;
            assert (exp_rx_q.size() != 0) else begin
                errors++;
                $error("FAIL rx_unexpected: observed 0x%0h expected no word", rx_data_o);
            end
            if (exp_rx_q.size() != 0) check("rx_data", rx_data_o, exp_rx_q.pop_front());
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_sd_o"},     sd_o,          0);
        check({pfx, "_sd_oe"},    sd_oe_o,       0);
        check({pfx, "_tx_ready"}, tx_ready_o,    1);
        check({pfx, "_rx_data"},  rx_data_o,     0);
        check({pfx, "_rx_valid"}, rx_valid_o,    0);
        check({pfx, "_underrun"}, tx_underrun_o, 0);
        check({pfx, "_busy"},     busy_o,        0);
    endtask

    task automatic write_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("tx_ready_wait", tx_ready_o, 1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic start_frame();
        ss_ni = 1'b0;
        repeat (8) @(posedge clk_i);
        #1;
    endtask

    // Host side, clk/8 SCLK. MISO is read late in the high phase to allow
    // for the target's oversampling delay. On the final bit of a frame the
    // host raises ss_n while SCLK is still high.
    task automatic xfer(input logic [7:0] mosi, input int nbits, input bit last,
                        input bit chk_lat, output logic [7:0] miso);
        miso = 8'h00;
        for (int n = 0; n < nbits; n++) begin
            sd_i = mosi[7-n];
            repeat (4) @(posedge clk_i);
            #1 sclk_i = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk_i); #1;
                if (chk_lat && n == 7)
                    check($sformatf("rx_latency_edge%0d", k), rx_valid_o, (k == 4) ? 1 : 0);
            end
            miso = {miso[6:0], sd_o};
            if (last && n == nbits - 1) begin
                ss_ni = 1'b1;
                repeat (4) @(posedge clk_i);
                #1;
            end
            sclk_i = 1'b0;
        end
        if (last) begin
            repeat (8) @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        logic [7:0] m1, m2;
        int r0, u0;

        // Reset with SCLK toggling and ss_n high
        for (int i = 0; i < 6; i++) begin
            repeat (2) @(posedge clk_i);
            #1 sclk_i = ~sclk_i;
        end
        check_reset_outputs("rst");
        @(posedge clk_i); #1 rst_ni = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat (2) @(posedge clk_i);
            #1 sclk_i = ~sclk_i;
        end
        sclk_i = 1'b0;
        repeat (4) @(posedge clk_i); #1;
        check("idle_rx_count", rx_cnt, 0);
        check("idle_busy", busy_o, 0);
        check("idle_sd_oe", sd_oe_o, 0);
        check("idle_tx_ready", tx_ready_o, 1);

        // Preloaded word 0x3C, host sends 0xA5
        r0 = rx_cnt; u0 = ur_cnt;
        write_tx(8'h3C);
        check("t1_tx_ready_full", tx_ready_o, 0);
        start_frame();
        check("t1_busy", busy_o, 1);
        check("t1_sd_oe", sd_oe_o, 1);
        check("t1_tx_ready_after_load", tx_ready_o, 1);
        exp_rx_q.push_back(8'hA5);
        xfer(8'hA5, 8, 1'b1, 1'b1, m1);
        check("t1_miso", m1, 8'h3C);
        check("t1_rx_count", rx_cnt - r0, 1);
        check("t1_underrun", ur_cnt - u0, 0);
        check("t1_busy_end", busy_o, 0);
        check("t1_sd_oe_end", sd_oe_o, 0);

        // Empty holding register: idle word and one underrun pulse
        r0 = rx_cnt; u0 = ur_cnt;
        start_frame();
        check("t2_underrun_start", ur_cnt - u0, 1);
        exp_rx_q.push_back(8'h00);
        xfer(8'h00, 8, 1'b1, 1'b0, m1);
        check("t2_miso", m1, 8'hFF);
        check("t2_underrun_total", ur_cnt - u0, 1);
        check("t2_rx_count", rx_cnt - r0, 1);

        // Two words in one frame, second TX word written after first load
        r0 = rx_cnt; u0 = ur_cnt;
        write_tx(8'h11);
        start_frame();
        write_tx(8'h22);
        exp_rx_q.push_back(8'h5A);
        exp_rx_q.push_back(8'hC3);
        xfer(8'h5A, 8, 1'b0, 1'b0, m1);
        xfer(8'hC3, 8, 1'b1, 1'b0, m2);
        check("t3_miso0", m1, 8'h11);
        check("t3_miso1", m2, 8'h22);
        check("t3_rx_count", rx_cnt - r0, 2);
        check("t3_underrun", ur_cnt - u0, 0);

        // Frame aborted after 5 SCLK rises, then a clean frame
        r0 = rx_cnt;
        start_frame();
        xfer(8'hF0, 5, 1'b1, 1'b0, m1);
        check("t4_rx_count_abort", rx_cnt - r0, 0);
        check("t4_busy", busy_o, 0);
        check("t4_sd_oe", sd_oe_o, 0);
        write_tx(8'h69);
        exp_rx_q.push_back(8'h81);
        start_frame();
        xfer(8'h81, 8, 1'b1, 1'b1, m1);
        check("t4_miso", m1, 8'h69);
        check("t4_rx_count", rx_cnt - r0, 1);

        // Reset pulsed mid-word; rest of frame ignored until ss_n cycles
        start_frame();
        xfer(8'hFF, 3, 1'b0, 1'b0, m1);
        @(posedge clk_i); #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("t5");
        @(posedge clk_i); #1 rst_ni = 1'b1;
        r0 = rx_cnt;
        xfer(8'hFF, 5, 1'b0, 1'b0, m1);
        xfer(8'h55, 8, 1'b0, 1'b0, m1);
        check("t5_busy_ignored", busy_o, 0);
        xfer(8'h55, 8, 1'b1, 1'b0, m1);
        check("t5_rx_count_ignored", rx_cnt - r0, 0);
        exp_rx_q.push_back(8'h96);
        start_frame();
        xfer(8'h96, 8, 1'b1, 1'b1, m1);
        check("t5_miso", m1, 8'hFF);
        check("t5_rx_count", rx_cnt - r0, 1);

        check("scoreboard_empty", exp_rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
